// File: rtl/hit_resolver.sv
// hit_resolver: per-frame hit counting, health/stun tracking and KO detection for two players.
// Define HITSTOP_EN to add a short gameplay freeze (HITSTOP state, freeze output) after each hit.
module hit_resolver #(
    parameter int unsigned HEALTH_INIT    = 100,
    parameter int unsigned DAMAGE         = 10,
    parameter int unsigned STUN_FRAMES    = 12,
    parameter int unsigned HITSTOP_FRAMES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    input  logic       i_round_restart,
    input  logic [1:0] i_hitresult,
    input  logic [3:0] i_p1_state,
    input  logic [3:0] i_p2_state,
    output logic [6:0] o_p1_health,
    output logic [6:0] o_p2_health,
    output logic       o_p1_stunned,
    output logic       o_p2_stunned,
    output logic       o_p1_hit_pulse,
    output logic       o_p2_hit_pulse,
    output logic       o_freeze,
    output logic       o_game_over,
    output logic [1:0] o_winner
);

`ifdef HITSTOP_EN
    typedef enum logic [1:0] {StFight, StHitstop, StKo} state_e;
    localparam logic [3:0] LP_HITSTOP = 4'(HITSTOP_FRAMES);
`else
    typedef enum logic [1:0] {StFight, StKo} state_e;
    logic w_unused_hitstop;
    assign w_unused_hitstop = ^4'(HITSTOP_FRAMES);
`endif

    localparam logic [6:0] LP_HEALTH = 7'(HEALTH_INIT);
    localparam logic [6:0] LP_DAMAGE = 7'(DAMAGE);
    localparam logic [4:0] LP_STUN   = 5'(STUN_FRAMES);
    localparam logic [3:0] LP_ATTACK = 4'd3;

    state_e     r_state, w_state_nxt;
    logic [6:0] r_p1_health, r_p2_health, w_p1_health_nxt, w_p2_health_nxt;
    logic [4:0] r_p1_stun, r_p2_stun, w_p1_stun_nxt, w_p2_stun_nxt;
    logic       r_p1_armed, r_p2_armed, w_p1_armed_nxt, w_p2_armed_nxt;
    logic       r_p1_pulse, r_p2_pulse, w_p1_pulse_nxt, w_p2_pulse_nxt;
    logic       r_game_over, w_game_over_nxt;
    logic [1:0] r_winner, w_winner_nxt;
    logic [3:0] r_hs_cnt, w_hs_cnt_nxt;

    logic       w_p1_arm, w_p2_arm, w_hit_on_p1, w_hit_on_p2;
    logic [6:0] w_p1_new_health, w_p2_new_health;
    logic       w_p1_zero, w_p2_zero;

    function automatic logic [6:0] take_damage(input logic [6:0] health);
        return (health <= LP_DAMAGE) ? 7'd0 : health - LP_DAMAGE;
    endfunction

    function automatic logic [4:0] stun_dec(input logic [4:0] cnt);
        return (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
    endfunction

    // Arming is folded in first so an attack-start frame with contact already counts.
    assign w_p1_arm        = r_p1_armed | (i_p1_state == LP_ATTACK);
    assign w_p2_arm        = r_p2_armed | (i_p2_state == LP_ATTACK);
    assign w_hit_on_p2     = i_hitresult[1] & w_p1_arm;
    assign w_hit_on_p1     = i_hitresult[0] & w_p2_arm;
    assign w_p1_new_health = w_hit_on_p1 ? take_damage(r_p1_health) : r_p1_health;
    assign w_p2_new_health = w_hit_on_p2 ? take_damage(r_p2_health) : r_p2_health;
    assign w_p1_zero       = (w_p1_new_health == 7'd0);
    assign w_p2_zero       = (w_p2_new_health == 7'd0);

    always_comb begin
        w_state_nxt     = r_state;
        w_p1_health_nxt = r_p1_health;
        w_p2_health_nxt = r_p2_health;
        w_p1_stun_nxt   = r_p1_stun;
        w_p2_stun_nxt   = r_p2_stun;
        w_p1_armed_nxt  = r_p1_armed;
        w_p2_armed_nxt  = r_p2_armed;
        w_p1_pulse_nxt  = 1'b0;
        w_p2_pulse_nxt  = 1'b0;
        w_game_over_nxt = r_game_over;
        w_winner_nxt    = r_winner;
        w_hs_cnt_nxt    = r_hs_cnt;

        if (i_round_restart) begin
            w_state_nxt     = StFight;
            w_p1_health_nxt = LP_HEALTH;
            w_p2_health_nxt = LP_HEALTH;
            w_p1_stun_nxt   = 5'd0;
            w_p2_stun_nxt   = 5'd0;
            w_p1_armed_nxt  = 1'b0;
            w_p2_armed_nxt  = 1'b0;
            w_game_over_nxt = 1'b0;
            w_winner_nxt    = 2'b00;
            w_hs_cnt_nxt    = 4'd0;
        end else if (i_frame_tick) begin
            case (r_state)
                StFight: begin
                    w_p1_armed_nxt  = w_p1_arm & ~w_hit_on_p2;
                    w_p2_armed_nxt  = w_p2_arm & ~w_hit_on_p1;
                    w_p1_health_nxt = w_p1_new_health;
                    w_p2_health_nxt = w_p2_new_health;
                    w_p1_stun_nxt   = w_hit_on_p1 ? LP_STUN : stun_dec(r_p1_stun);
                    w_p2_stun_nxt   = w_hit_on_p2 ? LP_STUN : stun_dec(r_p2_stun);
                    w_p1_pulse_nxt  = w_hit_on_p1;
                    w_p2_pulse_nxt  = w_hit_on_p2;
                    if (w_p1_zero || w_p2_zero) begin
                        w_state_nxt     = StKo;
                        w_winner_nxt    = {w_p1_zero, w_p2_zero};
                        w_game_over_nxt = 1'b1;
                        w_p1_stun_nxt   = 5'd0;
                        w_p2_stun_nxt   = 5'd0;
                    end
`ifdef HITSTOP_EN
                    else if (w_hit_on_p1 || w_hit_on_p2) begin
                        w_state_nxt  = StHitstop;
                        w_hs_cnt_nxt = LP_HITSTOP;
                    end
`endif
                end
`ifdef HITSTOP_EN
                StHitstop: begin
                    w_hs_cnt_nxt = (r_hs_cnt == 4'd0) ? 4'd0 : r_hs_cnt - 4'd1;
                    if (r_hs_cnt <= 4'd1) begin
                        w_state_nxt = StFight;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StFight;
            r_p1_health <= LP_HEALTH;
            r_p2_health <= LP_HEALTH;
            r_p1_stun   <= 5'd0;
            r_p2_stun   <= 5'd0;
            r_p1_armed  <= 1'b0;
            r_p2_armed  <= 1'b0;
            r_p1_pulse  <= 1'b0;
            r_p2_pulse  <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
            r_hs_cnt    <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_p1_health <= w_p1_health_nxt;
            r_p2_health <= w_p2_health_nxt;
            r_p1_stun   <= w_p1_stun_nxt;
            r_p2_stun   <= w_p2_stun_nxt;
            r_p1_armed  <= w_p1_armed_nxt;
            r_p2_armed  <= w_p2_armed_nxt;
            r_p1_pulse  <= w_p1_pulse_nxt;
            r_p2_pulse  <= w_p2_pulse_nxt;
            r_game_over <= w_game_over_nxt;
            r_winner    <= w_winner_nxt;
            r_hs_cnt    <= w_hs_cnt_nxt;
        end
    end

    assign o_p1_health    = r_p1_health;
    assign o_p2_health    = r_p2_health;
    assign o_p1_stunned   = |r_p1_stun;
    assign o_p2_stunned   = |r_p2_stun;
    assign o_p1_hit_pulse = r_p1_pulse;
    assign o_p2_hit_pulse = r_p2_pulse;
    assign o_game_over    = r_game_over;
    assign o_winner       = r_winner;
`ifdef HITSTOP_EN
    assign o_freeze       = (r_state == StHitstop);
`else
    assign o_freeze       = 1'b0;
`endif

endmodule
